// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down pushbutton controller.
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of a counter that must represent 0..n without wrapping.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/button_debounce_fsm.sv
// Synchronizer plus debounce FSM for one pushbutton; emits a one-cycle press event.
// Optional auto-repeat while held is enabled by UPDOWN_AUTOREPEAT_EN.
module button_debounce_fsm
    import updown_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_evt
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_debounce_fsm: cycle parameters must be at least 1");
    end

    logic btn_meta_q, btn_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          evt_q, evt_d;

`ifdef UPDOWN_AUTOREPEAT_EN
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q, rpt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
`ifdef UPDOWN_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d = IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HELD;
                    evt_d   = 1'b1;
`ifdef UPDOWN_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!btn_sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef UPDOWN_AUTOREPEAT_EN
                else if (rpt_q >= RPT_LAST) begin
                    evt_d = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                // Repeat counter is left untouched here so it resumes on bounce-back.
                if (btn_sync_q) begin
                    state_d = HELD;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign level     = (state_q == HELD) || (state_q == RELEASE_WAIT);
    assign press_evt = evt_q;

endmodule

// File: rtl/updown_button_ctrl.sv
// Two debounced pushbuttons arbitrated into a count strobe and direction.
// Auto-repeat while held is enabled by defining UPDOWN_AUTOREPEAT_EN.
module updown_button_ctrl
    import updown_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic Up_Down,
    output logic up_level,
    output logic down_level
);

    logic up_evt, down_evt;

    button_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_up),
        .level     (up_level),
        .press_evt (up_evt)
    );

    button_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_down),
        .level     (down_level),
        .press_evt (down_evt)
    );

    logic enable_q, enable_d;
    logic up_down_q, up_down_d;

    // Simultaneous events cancel; an event right after a strobe is dropped
    // so the strobe can never last two cycles.
    always_comb begin
        enable_d  = 1'b0;
        up_down_d = up_down_q;
        if (!enable_q) begin
            if (up_evt && !down_evt) begin
                enable_d  = 1'b1;
                up_down_d = DIR_UP;
            end else if (down_evt && !up_evt) begin
                enable_d  = 1'b1;
                up_down_d = DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q  <= 1'b0;
            up_down_q <= DIR_UP;
        end else begin
            enable_q  <= enable_d;
            up_down_q <= up_down_d;
        end
    end

    assign enable  = enable_q;
    assign Up_Down = up_down_q;

endmodule

// File: tb/tb_updown_button_ctrl.sv
// Directed self-checking bench for updown_button_ctrl (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_updown_button_ctrl;

`ifdef UPDOWN_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic enable, Up_Down, up_level, down_level;

    int n_tests = 0;
    int n_fail  = 0;

    updown_button_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .enable     (enable),
        .Up_Down    (Up_Down),
        .up_level   (up_level),
        .down_level (down_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Runs n edges (index 0 = first edge after the call) and summarises enable pulses.
    task automatic run_window(input int n, output int pulses, output int first_e,
                              output int last_e, output int first_dir, output int b2b,
                              output int up_seen, output int dn_seen);
        int prev;
        pulses = 0; first_e = -1; last_e = -1; first_dir = -1; b2b = 0;
        up_seen = 0; dn_seen = 0; prev = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (enable === 1'b1) begin
                if (prev != 0) b2b++;
                if (pulses == 0) begin
                    first_e   = i;
                    first_dir = int'(Up_Down);
                end
                last_e = i;
                pulses++;
            end
            prev = (enable === 1'b1) ? 1 : 0;
            if (up_level === 1'b1) up_seen = 1;
            if (down_level === 1'b1) dn_seen = 1;
        end
    endtask

    initial begin
        int p, fe, le, fd, bb, us, ds, acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_enable", int'(enable), 0);
        check_eq("rst_up_down", int'(Up_Down), 1);
        check_eq("rst_up_level", int'(up_level), 0);
        check_eq("rst_down_level", int'(down_level), 0);
        rst = 1'b0;
        run_window(4, p, fe, le, fd, bb, us, ds);
        check_eq("idle_pulses", p, 0);

        // Clean up press held 20 cycles
        btn_up = 1'b1;
        run_window(20, p, fe, le, fd, bb, us, ds);
        check_eq("up_pulses", p, AR ? 2 : 1);
        check_eq("up_first_edge", fe, 7);
        check_eq("up_dir", fd, 1);
        check_eq("up_b2b", bb, 0);
        check_eq("up_level_held", int'(up_level), 1);
        btn_up = 1'b0;
        run_window(12, p, fe, le, fd, bb, us, ds);
        check_eq("up_release_pulses", p, 0);
        check_eq("up_level_released", int'(up_level), 0);

        // Bouncing down press: 1-0-1-0 then held
        acc = 0;
        btn_down = 1'b1; run_window(1, p, fe, le, fd, bb, us, ds); acc += p;
        btn_down = 1'b0; run_window(1, p, fe, le, fd, bb, us, ds); acc += p;
        btn_down = 1'b1; run_window(1, p, fe, le, fd, bb, us, ds); acc += p;
        btn_down = 1'b0; run_window(1, p, fe, le, fd, bb, us, ds); acc += p;
        check_eq("bounce_pulses", acc, 0);
        btn_down = 1'b1;
        run_window(20, p, fe, le, fd, bb, us, ds);
        check_eq("down_pulses", p, AR ? 2 : 1);
        check_eq("down_first_edge", fe, 7);
        check_eq("down_dir", fd, 0);
        check_eq("down_level_held", int'(down_level), 1);
        btn_down = 1'b0;
        run_window(12, p, fe, le, fd, bb, us, ds);
        check_eq("down_release_pulses", p, 0);

        // 3-cycle glitch on up
        btn_up = 1'b1;
        run_window(3, p, fe, le, fd, bb, us, ds);
        acc = p;
        btn_up = 1'b0;
        run_window(17, p, fe, le, fd, bb, us, ds);
        check_eq("glitch_pulses", acc + p, 0);
        check_eq("glitch_level", us, 0);
        check_eq("glitch_dir_kept", int'(Up_Down), 0);

        // Both buttons on the same edge
        btn_up = 1'b1;
        btn_down = 1'b1;
        run_window(20, p, fe, le, fd, bb, us, ds);
        check_eq("both_pulses", p, 0);
        check_eq("both_dir_kept", int'(Up_Down), 0);
        check_eq("both_levels", us + ds, 2);
        btn_up = 1'b0;
        btn_down = 1'b0;
        run_window(12, p, fe, le, fd, bb, us, ds);

        // Reset 2 cycles into an up press, button held through reset release
        btn_up = 1'b1;
        run_window(2, p, fe, le, fd, bb, us, ds);
        acc = p;
        rst = 1'b1;
        #1;
        check_eq("midrst_enable", int'(enable), 0);
        check_eq("midrst_up_down", int'(Up_Down), 1);
        check_eq("midrst_levels", int'(up_level) + int'(down_level), 0);
        run_window(2, p, fe, le, fd, bb, us, ds);
        check_eq("midrst_pulses", acc + p, 0);
        rst = 1'b0;
        run_window(20, p, fe, le, fd, bb, us, ds);
        check_eq("postrst_pulses", p, AR ? 2 : 1);
        check_eq("postrst_first_edge", fe, 7);
        check_eq("postrst_dir", fd, 1);
        btn_up = 1'b0;
        run_window(12, p, fe, le, fd, bb, us, ds);

        // Long hold: auto-repeat cadence (or single event without it)
        btn_up = 1'b1;
        run_window(34, p, fe, le, fd, bb, us, ds);
        check_eq("hold_pulses", p, AR ? 4 : 1);
        check_eq("hold_first_edge", fe, 7);
        check_eq("hold_last_edge", le, AR ? 31 : 7);
        check_eq("hold_b2b", bb, 0);
        btn_up = 1'b0;
        run_window(12, p, fe, le, fd, bb, us, ds);
        check_eq("hold_release_pulses", p, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_button_ctrl.md
UPDOWN_BUTTON_CTRL -- requirements
Module: updown_button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk cycles that qualify a press or release.
REQ-002 Parameter REPEAT_CYCLES, default 25000000, auto-repeat period in clk cycles; used only when REQ-027 applies.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset: asynchronous, active-high.
REQ-005 Port btn_up  input  1  raw, asynchronous, bouncing up pushbutton; active-high.
REQ-006 Port btn_down  input  1  raw, asynchronous, bouncing down pushbutton; active-high.
REQ-007 Port enable  output  1  single-cycle count strobe for the downstream up/down counter.
REQ-008 Port Up_Down  output  1  count direction: 1 = up, 0 = down; valid whenever enable = 1.
REQ-009 Port up_level  output  1  debounced level of btn_up; high in states HELD and RELEASE_WAIT.
REQ-010 Port down_level  output  1  debounced level of btn_down; high in states HELD and RELEASE_WAIT.

Function
REQ-011 Each button passes through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized button drives an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 FSM transitions:
- IDLE -> PRESS_WAIT on sync=1, counter cleared.
- PRESS_WAIT -> IDLE on sync=0.
- PRESS_WAIT -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with sync=1.
- HELD -> RELEASE_WAIT on sync=0, counter cleared.
- RELEASE_WAIT -> HELD on sync=1.
- RELEASE_WAIT -> IDLE when the counter reaches DEBOUNCE_CYCLES-1 with sync=0.
REQ-014 The counter width is clog2(DEBOUNCE_CYCLES)+1 bits; the counter saturates and never wraps.
REQ-015 Each PRESS_WAIT -> HELD transition generates exactly one press event for that button; a release generates no event.
REQ-016 Latency: with the raw input held steady, enable is high for exactly one cycle, starting DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high.
REQ-017 An up press event alone gives enable=1 with Up_Down=1; a down press event alone gives enable=1 with Up_Down=0.
REQ-018 Press events from both buttons in the same cycle are discarded: enable=0 and Up_Down unchanged.
REQ-019 Up_Down is registered and holds its last direction between events.
REQ-020 enable is never high for two consecutive cycles.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES in either direction produces no event and no level change.

Reset
REQ-022 On rst: enable=0, Up_Down=1, up_level=0, down_level=0.
REQ-023 On rst: both FSMs go to IDLE and all counters and synchronizer flops clear to 0.
REQ-024 A button held through the release of rst is treated as a new press and produces one event after the REQ-016 latency.
REQ-025 rst asserted during PRESS_WAIT aborts the pending event; no enable pulse occurs.

Configuration
REQ-026 Auto-repeat is controlled by the macro UPDOWN_AUTOREPEAT_EN.
REQ-027 With UPDOWN_AUTOREPEAT_EN defined:
- Each FSM in HELD carries a repeat counter.
- The FSM emits one further press event every REPEAT_CYCLES cycles while it remains in HELD.
- The repeat counter restarts on entry to HELD.
- The repeat counter freezes in RELEASE_WAIT and resumes if the FSM returns to HELD.
- REQ-018 applies to repeat events.
REQ-028 Without UPDOWN_AUTOREPEAT_EN:
- No repeat counter logic is generated.
- A held button produces exactly one event.
- REPEAT_CYCLES is ignored.

Structure
REQ-029 A shared package updown_pkg holds the FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-030 Synchronizer, FSM, debounce counter and optional repeat counter form sub-module button_debounce_fsm (outputs: level, press_evt); it is instantiated twice.
REQ-031 The top level contains only the two instances, the REQ-017/018 arbitration and the output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-032 Clean btn_up rise held 20 cycles -> one enable pulse, 7 edges after the first sample, with Up_Down=1; up_level high.
REQ-033 btn_down bouncing 1-0-1-0 at 1-cycle spacing, then held -> exactly one enable pulse with Up_Down=0, timed from the last rising edge.
REQ-034 3-cycle glitch on btn_up -> no enable pulse; up_level stays 0.
REQ-035 Both buttons rise on the same edge -> no enable pulse; Up_Down stays at its prior value.
REQ-036 rst pulsed 2 cycles after btn_up rises -> no pulse in flight; all outputs at reset values; one pulse 7 edges after rst deasserts.
REQ-037 With UPDOWN_AUTOREPEAT_EN, btn_up held 30 cycles -> events at press+0, +8, +16 and +24 cycles; without the macro -> one event.
